// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM stage: FSM state encoding, datapath widths and
// the access-timeout limit used when MEM_ACCESS_TIMEOUT_EN is defined.
package cpu_pkg;

  localparam int unsigned AddrWidth       = 32;
  localparam int unsigned DataWidth       = 32;
  localparam int unsigned RegIdxWidth     = 5;
  localparam int unsigned TimeoutCntWidth = 4;

  // Number of un-acked WAIT cycles counted before the access is abandoned.
  localparam logic [TimeoutCntWidth-1:0] TimeoutLimit = 4'd15;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } ma_state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// MEM-stage control FSM (IDLE/WAIT) plus the optional access-timeout counter.
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN (abandon an access after
// TimeoutLimit un-acked WAIT cycles).
//
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   valid_i       EX/MEM slot holds a real instruction
//   mem_op_i      instruction is a load or store
//   aligned_i     effective address is word aligned
//   dm_ack_i      data memory completes the outstanding request
//   busy_o        FSM is in WAIT (request outstanding)
//   start_o       aligned memory op accepted this cycle; datapath latches it
//   done_o        outstanding request acked this cycle; WB loads latched values
//   stall_o       freeze EX/MEM and upstream stages
//   err_o         one-cycle pulse on misaligned access or timeout
module mem_access_ctrl
  import cpu_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic mem_op_i,
  input  logic aligned_i,
  input  logic dm_ack_i,
  output logic busy_o,
  output logic start_o,
  output logic done_o,
  output logic stall_o,
  output logic err_o
);

  ma_state_e state_q, state_d;
  logic      timeout;

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [TimeoutCntWidth-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == StWait) && !dm_ack_i && (cnt_q == TimeoutLimit);

  always_comb begin
    cnt_d = cnt_q;
    if (start_o) begin
      cnt_d = '0;
    end else if ((state_q == StWait) && !dm_ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    start_o = 1'b0;
    done_o  = 1'b0;
    stall_o = 1'b0;
    err_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // dm_ack_i is deliberately ignored here: no request is outstanding.
        if (valid_i && mem_op_i) begin
          if (aligned_i) begin
            start_o = 1'b1;
            stall_o = 1'b1;
            state_d = StWait;
          end else begin
            err_o = 1'b1;
          end
        end
      end
      StWait: begin
        if (dm_ack_i) begin
          done_o  = 1'b1;
          state_d = StIdle;
        end else if (timeout) begin
          err_o   = 1'b1;
          state_d = StIdle;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy_o = (state_q == StWait);

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues word-aligned loads/stores to a handshaked data
// memory, stalls the pipeline while waiting for the ack, and drives the MEM/WB
// register. Optional feature macro: MEM_ACCESS_TIMEOUT_EN (see mem_access_ctrl).
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   valid_i, mem_read_i, mem_write_i, reg_write_i, mem_to_reg_i,
//   alu_result_i, write_data_i, rd_i   EX/MEM register contents
//   stall_o                        freeze EX/MEM and upstream this cycle
//   dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o   data-memory request (WAIT only)
//   dm_ack_i, dm_rdata_i           data-memory completion and load data
//   wb_*_o                         MEM/WB register outputs
//   err_o                          misaligned-access / timeout pulse
module mem_access
  import cpu_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic                   mem_read_i,
  input  logic                   mem_write_i,
  input  logic                   reg_write_i,
  input  logic                   mem_to_reg_i,
  input  logic [AddrWidth-1:0]   alu_result_i,
  input  logic [DataWidth-1:0]   write_data_i,
  input  logic [RegIdxWidth-1:0] rd_i,
  output logic                   stall_o,
  output logic                   dm_req_o,
  output logic                   dm_we_o,
  output logic [AddrWidth-1:0]   dm_addr_o,
  output logic [DataWidth-1:0]   dm_wdata_o,
  input  logic                   dm_ack_i,
  input  logic [DataWidth-1:0]   dm_rdata_i,
  output logic                   wb_valid_o,
  output logic                   wb_reg_write_o,
  output logic                   wb_mem_to_reg_o,
  output logic [DataWidth-1:0]   wb_read_data_o,
  output logic [AddrWidth-1:0]   wb_alu_result_o,
  output logic [RegIdxWidth-1:0] wb_rd_o,
  output logic                   err_o
);

  logic mem_op, aligned, busy, start, done;

  assign mem_op  = mem_read_i | mem_write_i;
  assign aligned = (alu_result_i[1:0] == 2'b00);

  mem_access_ctrl u_ctrl (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .mem_op_i (mem_op),
    .aligned_i(aligned),
    .dm_ack_i (dm_ack_i),
    .busy_o   (busy),
    .start_o  (start),
    .done_o   (done),
    .stall_o  (stall_o),
    .err_o    (err_o)
  );

  // Request latched on acceptance so the memory sees stable values until ack.
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic                   we_q;
  logic [RegIdxWidth-1:0] rd_q;
  logic                   reg_write_q;
  logic                   mem_to_reg_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (start) begin
      addr_q       <= alu_result_i;
      wdata_q      <= write_data_i;
      we_q         <= mem_write_i;  // read+write together is a store
      rd_q         <= rd_i;
      reg_write_q  <= reg_write_i;
      mem_to_reg_q <= mem_to_reg_i;
    end
  end

  always_comb begin
    dm_req_o   = 1'b0;
    dm_we_o    = 1'b0;
    dm_addr_o  = '0;
    dm_wdata_o = '0;
    if (busy) begin
      dm_req_o   = 1'b1;
      dm_we_o    = we_q;
      dm_addr_o  = addr_q;
      dm_wdata_o = wdata_q;
    end
  end

  // MEM/WB register
  logic                   wb_valid_q, wb_reg_write_q, wb_mem_to_reg_q;
  logic [DataWidth-1:0]   wb_read_data_q;
  logic [AddrWidth-1:0]   wb_alu_result_q;
  logic [RegIdxWidth-1:0] wb_rd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_read_data_q  <= '0;
      wb_alu_result_q <= '0;
      wb_rd_q         <= '0;
    end else if (done) begin
      wb_valid_q      <= 1'b1;
      wb_reg_write_q  <= reg_write_q;
      wb_mem_to_reg_q <= mem_to_reg_q;
      wb_read_data_q  <= we_q ? '0 : dm_rdata_i;
      wb_alu_result_q <= addr_q;
      wb_rd_q         <= rd_q;
    end else if (!busy && valid_i && !mem_op) begin
      wb_valid_q      <= 1'b1;
      wb_reg_write_q  <= reg_write_i;
      wb_mem_to_reg_q <= mem_to_reg_i;
      wb_read_data_q  <= '0;
      wb_alu_result_q <= alu_result_i;
      wb_rd_q         <= rd_i;
    end else begin
      // Bubble: no instruction retires, so nothing may be written back.
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
    end
  end

  assign wb_valid_o      = wb_valid_q;
  assign wb_reg_write_o  = wb_reg_write_q;
  assign wb_mem_to_reg_o = wb_mem_to_reg_q;
  assign wb_read_data_o  = wb_read_data_q;
  assign wb_alu_result_o = wb_alu_result_q;
  assign wb_rd_o         = wb_rd_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: a transaction-level model predicts the
// request and MEM/WB outputs every cycle, plus directed literal checks.
module tb_mem_access;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif
  localparam int ToLimit = 15;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i, mem_read_i, mem_write_i, reg_write_i, mem_to_reg_i;
  logic [31:0] alu_result_i, write_data_i, dm_rdata_i;
  logic [4:0]  rd_i;
  logic        dm_ack_i;
  logic        stall_o, dm_req_o, dm_we_o, err_o;
  logic [31:0] dm_addr_o, dm_wdata_o;
  logic        wb_valid_o, wb_reg_write_o, wb_mem_to_reg_o;
  logic [31:0] wb_read_data_o, wb_alu_result_o;
  logic [4:0]  wb_rd_o;

  always #5 clk = ~clk;

  mem_access dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .mem_read_i     (mem_read_i),
    .mem_write_i    (mem_write_i),
    .reg_write_i    (reg_write_i),
    .mem_to_reg_i   (mem_to_reg_i),
    .alu_result_i   (alu_result_i),
    .write_data_i   (write_data_i),
    .rd_i           (rd_i),
    .stall_o        (stall_o),
    .dm_req_o       (dm_req_o),
    .dm_we_o        (dm_we_o),
    .dm_addr_o      (dm_addr_o),
    .dm_wdata_o     (dm_wdata_o),
    .dm_ack_i       (dm_ack_i),
    .dm_rdata_i     (dm_rdata_i),
    .wb_valid_o     (wb_valid_o),
    .wb_reg_write_o (wb_reg_write_o),
    .wb_mem_to_reg_o(wb_mem_to_reg_o),
    .wb_read_data_o (wb_read_data_o),
    .wb_alu_result_o(wb_alu_result_o),
    .wb_rd_o        (wb_rd_o),
    .err_o          (err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: one outstanding access plus expected WB contents
  bit          m_busy;
  bit          m_we, m_rw, m_mtr;
  logic [31:0] m_addr, m_wdata;
  logic [4:0]  m_rd;
  int          m_waited;
  bit          e_valid, e_rw, e_mtr;
  logic [31:0] e_rdata, e_alu;
  logic [4:0]  e_rd;

  always @(posedge clk) begin
    if (rst_i) begin
      m_busy <= 1'b0; m_waited <= 0;
      e_valid <= 1'b0; e_rw <= 1'b0; e_mtr <= 1'b0;
      e_rdata <= '0; e_alu <= '0; e_rd <= '0;
    end else begin
      e_valid <= 1'b0; e_rw <= 1'b0; e_mtr <= 1'b0;
      if (!m_busy) begin
        if (valid_i && (mem_read_i || mem_write_i)) begin
          if (alu_result_i[1:0] == 2'b00) begin
            m_busy <= 1'b1; m_waited <= 0;
            m_addr <= alu_result_i; m_wdata <= write_data_i; m_we <= mem_write_i;
            m_rd <= rd_i; m_rw <= reg_write_i; m_mtr <= mem_to_reg_i;
          end
        end else if (valid_i) begin
          e_valid <= 1'b1; e_rw <= reg_write_i; e_mtr <= mem_to_reg_i;
          e_rdata <= '0; e_alu <= alu_result_i; e_rd <= rd_i;
        end
      end else if (dm_ack_i) begin
        m_busy <= 1'b0;
        e_valid <= 1'b1; e_rw <= m_rw; e_mtr <= m_mtr;
        e_rdata <= m_we ? 32'h0 : dm_rdata_i; e_alu <= m_addr; e_rd <= m_rd;
      end else if (TimeoutEn && m_waited == ToLimit) begin
        m_busy <= 1'b0;
      end else begin
        m_waited <= m_waited + 1;
      end
    end
  end

  function automatic void exp_comb(output bit req, output bit we, output logic [31:0] addr,
                                   output logic [31:0] wdata, output bit stall,
                                   output bit err);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; stall = 1'b0; err = 1'b0;
    if (m_busy) begin
      req = 1'b1; we = m_we; addr = m_addr; wdata = m_wdata;
      if (dm_ack_i) stall = 1'b0;
      else if (TimeoutEn && m_waited == ToLimit) err = 1'b1;
      else stall = 1'b1;
    end else if (valid_i && (mem_read_i || mem_write_i)) begin
      if (alu_result_i[1:0] == 2'b00) stall = 1'b1;
      else err = 1'b1;
    end
  endfunction

  always @(negedge clk) begin : compare
    bit          x_req, x_we, x_stall, x_err;
    logic [31:0] x_addr, x_wdata;
    if (chk_en && !rst_i) begin
      exp_comb(x_req, x_we, x_addr, x_wdata, x_stall, x_err);
      chk1("m_dm_req", dm_req_o, x_req);
      chk1("m_dm_we", dm_we_o, x_we);
      chk32("m_dm_addr", dm_addr_o, x_addr);
      chk32("m_dm_wdata", dm_wdata_o, x_wdata);
      chk1("m_stall", stall_o, x_stall);
      chk1("m_err", err_o, x_err);
      chk1("m_wb_valid", wb_valid_o, e_valid);
      chk1("m_wb_reg_write", wb_reg_write_o, e_rw);
      if (e_valid) begin
        chk1("m_wb_mem_to_reg", wb_mem_to_reg_o, e_mtr);
        chk32("m_wb_read_data", wb_read_data_o, e_rdata);
        chk32("m_wb_alu", wb_alu_result_o, e_alu);
        chk32("m_wb_rd", {27'd0, wb_rd_o}, {27'd0, e_rd});
      end
    end
  end

  // ---------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 0; mem_read_i = 0; mem_write_i = 0; reg_write_i = 0; mem_to_reg_i = 0;
    alu_result_i = '0; write_data_i = '0; rd_i = '0; dm_ack_i = 0; dm_rdata_i = '0;
  endtask

  // Present a memory op, hold it while stalled, ack in cycle ack_after (0 = issue).
  task automatic do_mem(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] dst, input bit rw,
                        input bit mtr, input int ack_after, input logic [31:0] rdata,
                        output int stalls, output bit ack_we, output logic [31:0] ack_wdata);
    stalls = 0; ack_we = 0; ack_wdata = '0;
    valid_i = 1; mem_read_i = rd; mem_write_i = wr; alu_result_i = addr;
    write_data_i = wdata; rd_i = dst; reg_write_i = rw; mem_to_reg_i = mtr;
    for (int c = 0; c <= ack_after; c++) begin
      if (c == ack_after) begin
        dm_ack_i = 1; dm_rdata_i = rdata;
      end
      @(negedge clk);
      if (stall_o) stalls++;
      if (c >= 1) chk32("addr_hold", dm_addr_o, addr);
      if (c == ack_after) begin
        chk1("ack_stall", stall_o, 1'b0);
        ack_we = dm_we_o; ack_wdata = dm_wdata_o;
      end
      tick();
    end
    idle_inputs();
  endtask

  int          stalls;
  bit          a_we;
  logic [31:0] a_wd;

  initial begin
    idle_inputs();
    rst_i = 1;
    tick(); tick();
    rst_i = 0; chk_en = 1;
    @(negedge clk);
    chk1("rst_wb_valid", wb_valid_o, 1'b0);
    chk32("rst_wb_alu", wb_alu_result_o, 32'h0);
    chk1("rst_stall", stall_o, 1'b0);
    tick();

    // ALU op: one-cycle latency, no stall
    valid_i = 1; alu_result_i = 32'h10; rd_i = 5'd3; reg_write_i = 1;
    @(negedge clk); chk1("alu_stall", stall_o, 1'b0);
    tick(); idle_inputs();
    @(negedge clk);
    chk1("alu_wb_valid", wb_valid_o, 1'b1);
    chk32("alu_wb_alu", wb_alu_result_o, 32'h10);
    chk32("alu_wb_rd", {27'd0, wb_rd_o}, 32'd3);
    chk1("alu_stall2", stall_o, 1'b0);
    tick();

    // Load at 0x100, ack three cycles after issue
    do_mem(1, 0, 32'h100, 32'h0, 5'd5, 1, 1, 3, 32'hDEADBEEF, stalls, a_we, a_wd);
    @(negedge clk);
    chk32("load_stalls", stalls, 32'd3);
    chk1("load_wb_valid", wb_valid_o, 1'b1);
    chk32("load_wb_data", wb_read_data_o, 32'hDEADBEEF);
    tick();

    // Store at 0x204, ack on first WAIT cycle
    do_mem(0, 1, 32'h204, 32'h12345678, 5'd7, 0, 0, 1, 32'hCAFEF00D, stalls, a_we, a_wd);
    @(negedge clk);
    chk1("store_we", a_we, 1'b1);
    chk32("store_wdata", a_wd, 32'h12345678);
    chk1("store_wb_valid", wb_valid_o, 1'b1);
    chk1("store_wb_rw", wb_reg_write_o, 1'b0);
    chk32("store_wb_data", wb_read_data_o, 32'h0);
    tick();

    // Read and write together behave as a store
    do_mem(1, 1, 32'h300, 32'hA5A5A5A5, 5'd9, 0, 0, 2, 32'h11111111, stalls, a_we, a_wd);
    @(negedge clk);
    chk1("both_we", a_we, 1'b1);
    chk32("both_wb_data", wb_read_data_o, 32'h0);
    tick();

    // Misaligned load
    valid_i = 1; mem_read_i = 1; alu_result_i = 32'h102; rd_i = 5'd4; reg_write_i = 1;
    mem_to_reg_i = 1;
    @(negedge clk);
    chk1("mis_err", err_o, 1'b1);
    chk1("mis_stall", stall_o, 1'b0);
    chk1("mis_req", dm_req_o, 1'b0);
    tick(); idle_inputs();
    @(negedge clk);
    chk1("mis_err_off", err_o, 1'b0);
    chk1("mis_wb_valid", wb_valid_o, 1'b0);
    chk1("mis_wb_rw", wb_reg_write_o, 1'b0);
    tick();

    // Stray ack in IDLE is ignored
    dm_ack_i = 1; dm_rdata_i = 32'hFFFFFFFF;
    @(negedge clk); chk1("idle_ack_stall", stall_o, 1'b0);
    tick(); idle_inputs();
    @(negedge clk); chk1("idle_ack_wb", wb_valid_o, 1'b0);
    tick();

    // Reset in the second WAIT cycle, ack the cycle after
    valid_i = 1; mem_read_i = 1; alu_result_i = 32'h400; rd_i = 5'd2; reg_write_i = 1;
    tick(); tick();
    rst_i = 1;
    tick();
    rst_i = 0; idle_inputs(); dm_ack_i = 1; dm_rdata_i = 32'h55;
    @(negedge clk);
    chk1("rstw_req", dm_req_o, 1'b0);
    chk1("rstw_stall", stall_o, 1'b0);
    chk1("rstw_wb_valid", wb_valid_o, 1'b0);
    chk32("rstw_wb_alu", wb_alu_result_o, 32'h0);
    chk32("rstw_wb_data", wb_read_data_o, 32'h0);
    tick(); dm_ack_i = 0;
    @(negedge clk); chk1("rstw_ack_ignored", wb_valid_o, 1'b0);
    tick();

`ifdef MEM_ACCESS_TIMEOUT_EN
    begin
      int  wstall;
      bit  seen;
      wstall = 0; seen = 0;
      valid_i = 1; mem_read_i = 1; alu_result_i = 32'h500; rd_i = 5'd6; reg_write_i = 1;
      tick();
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (err_o) begin
          seen = 1;
          chk1("to_stall_at_err", stall_o, 1'b0);
          break;
        end
        if (stall_o) wstall++;
        tick();
      end
      chk1("to_err_seen", seen, 1'b1);
      chk32("to_wait_stalls", wstall, 32'd15);
      tick(); idle_inputs();
      @(negedge clk); chk1("to_wb_valid", wb_valid_o, 1'b0);
      tick();
    end
`else
    // Without timeout the access waits as long as it takes
    do_mem(1, 0, 32'h500, 32'h0, 5'd6, 1, 1, 20, 32'h0BADF00D, stalls, a_we, a_wd);
    @(negedge clk);
    chk32("long_stalls", stalls, 32'd20);
    chk32("long_wb_data", wb_read_data_o, 32'h0BADF00D);
    tick();
`endif

    // ALU op right after a memory op
    valid_i = 1; alu_result_i = 32'hFFFFFFFC; rd_i = 5'd31; reg_write_i = 1;
    tick(); idle_inputs();
    @(negedge clk);
    chk32("alu2_wb_alu", wb_alu_result_o, 32'hFFFFFFFC);
    chk32("alu2_wb_rd", {27'd0, wb_rd_o}, 32'd31);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-002 rst_i  in  1  reset, synchronous, active-high.
REQ-003 valid_i  in  1  EX/MEM slot holds a real instruction.
REQ-004 mem_read_i / mem_write_i  in  1 each  load / store request from EX/MEM.
REQ-005 reg_write_i / mem_to_reg_i  in  1 each  WB controls passed through.
REQ-006 alu_result_i  in  32  effective address or ALU result.
REQ-007 write_data_i  in  32  store data.
REQ-008 rd_i  in  5  destination register.
REQ-009 stall_o  out  1  freeze EX/MEM and all upstream stages this cycle.
REQ-010 dm_req_o / dm_we_o  out  1 each  data-memory request / write enable.
REQ-011 dm_addr_o / dm_wdata_o  out  32 each  data-memory address / write data.
REQ-012 dm_ack_i  in  1  memory completes the current request this cycle.
REQ-013 dm_rdata_i  in  32  load data, valid with dm_ack_i.
REQ-014 wb_valid_o, wb_reg_write_o, wb_mem_to_reg_o  out  1 each  MEM/WB register outputs.
REQ-015 wb_read_data_o / wb_alu_result_o  out  32 each;  wb_rd_o  out  5.
REQ-016 err_o  out  1  one-cycle pulse on a misaligned access or timeout.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE and WAIT.
REQ-018 IDLE, with valid_i=1 and no memory op: WB outputs SHALL load at the next edge (1-cycle latency), with wb_read_data_o=0 and stall_o=0.
REQ-019 IDLE, with valid_i=1, a memory op and alu_result_i[1:0]=0: stall_o SHALL be 1 combinationally; address, data, rd and controls SHALL be latched; the FSM SHALL go to WAIT; wb_valid_o SHALL be 0 at the next edge (bubble).
REQ-020 WAIT: dm_req_o SHALL be 1 and dm_addr_o, dm_we_o and dm_wdata_o SHALL hold their latched values, stable until the ack.
REQ-021 WAIT without dm_ack_i: stall_o SHALL be 1 and wb_valid_o SHALL be 0.
REQ-022 WAIT with dm_ack_i: stall_o SHALL be 0 in that same cycle; at the edge the latched controls and rd SHALL load into the WB outputs, wb_read_data_o SHALL load dm_rdata_i for a load or 0 for a store, and the FSM SHALL return to IDLE.
REQ-023 When mem_read_i and mem_write_i are both 1, the access SHALL be treated as a store.
REQ-024 A misaligned memory op SHALL issue no request, pulse err_o, clear wb_valid_o and wb_reg_write_o, and leave stall_o at 0.
REQ-025 When wb_valid_o=0, wb_reg_write_o SHALL also be 0.
REQ-026 dm_req_o, dm_we_o, dm_addr_o and dm_wdata_o SHALL be 0 outside WAIT.
REQ-027 dm_ack_i in IDLE SHALL be ignored.

Reset
REQ-028 While rst_i=1 at an edge, the FSM SHALL go to IDLE and every registered output SHALL go to 0; stall_o and dm_req_o SHALL be 0 in the following cycle.
REQ-029 A reset during WAIT SHALL abandon the request; a later dm_ack_i SHALL be ignored per REQ-027.

Configuration
REQ-030 With MEM_ACCESS_TIMEOUT_EN defined, a 4-bit counter SHALL clear on entry to WAIT and count each WAIT cycle without ack; at count 15 with no ack, the block SHALL pulse err_o, go to IDLE, hold wb_valid_o=0 and release stall_o in that cycle.
REQ-031 Without MEM_ACCESS_TIMEOUT_EN, WAIT SHALL persist until dm_ack_i and no counter logic SHALL exist.

Structure
REQ-032 cpu_pkg SHALL hold the state encoding (IDLE=0, WAIT=1), the address and data width (32), the register-index width (5) and the timeout limit (15).
REQ-033 The FSM and the optional timeout counter SHALL live in one sub-module, mem_access_ctrl; the datapath latches stay in mem_access.

Verification
REQ-034 ALU op (valid_i=1, alu_result_i=0x0000_0010, rd_i=3, reg_write_i=1) -> next cycle wb_valid_o=1, wb_alu_result_o=0x10, wb_rd_o=3, stall_o=0 throughout.
REQ-035 Load at 0x100, ack after 3 cycles with rdata=0xDEADBEEF -> stall_o=1 for 3 cycles then 0 in the ack cycle; wb_read_data_o=0xDEADBEEF and wb_valid_o=1 after that edge; dm_addr_o=0x100 stable during WAIT.
REQ-036 Store at 0x204 with data 0x12345678, ack on the first WAIT cycle -> dm_we_o=1, dm_wdata_o=0x12345678; wb_reg_write_o=0 and wb_read_data_o=0 after completion.
REQ-037 Load at 0x0000_0102 -> no dm_req_o, a single-cycle err_o pulse, wb_valid_o=0, stall_o never 1.
REQ-038 Load, rst_i=1 on the second WAIT cycle, ack arrives the following cycle -> all outputs 0 after reset, ack ignored, FSM in IDLE.
REQ-039 MEM_ACCESS_TIMEOUT_EN defined, load never acked -> stall_o=1 for 15 cycles, then err_o pulse and stall_o=0 in the same cycle, wb_valid_o=0.
